frame_pixel_compositor: RTL and testbench

//  Consumes the VGA timing generator's CounterX/CounterY, hblank/vblank and h/v sync and produces final 12-bit RGB.

---
 rtl/frame_pixel_compositor.sv | 154 +++++++++++++++
 tb/tb_frame_pixel_compositor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_compositor.sv
`default_nettype none
// =============================================================================
// Module  : frame_pixel_compositor
// Brief   : Three-stage sky/ground/pipe/bird compositor with sticky collision
//           flag and sync/blank re-timed to line up with the RGB output.
// Revision: 1.0 - initial release
// =============================================================================
module frame_pixel_compositor #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int PIPE_W   = 52,
  parameter int GAP_H    = 100,
  parameter int GROUND_Y = 440
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] CounterX,
  input  logic [15:0] CounterY,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [9:0]  bird_x,
  input  logic [9:0]  bird_y,
  input  logic [9:0]  pipe_x,
  input  logic [9:0]  gap_y,
  output logic [7:0]  spr_addr,
  input  logic [12:0] spr_data,
  input  logic        collision_clr,
  output logic [11:0] rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        blank_out,
  output logic        frame_start,
  output logic        collision
);

  localparam int          COL_W      = $clog2(SPR_W);
  localparam int          ROW_W      = $clog2(SPR_H);
  localparam logic [10:0] C_SPR_W    = 11'(SPR_W);
  localparam logic [10:0] C_SPR_H    = 11'(SPR_H);
  localparam logic [10:0] C_PIPE_W   = 11'(PIPE_W);
  localparam logic [10:0] C_GAP_H    = 11'(GAP_H);
  localparam logic [15:0] C_GROUND_Y = 16'(GROUND_Y);
  localparam logic [11:0] C_PIPE_RGB = 12'h2A2;
  localparam logic [11:0] C_GND_RGB  = 12'hC95;
  localparam logic [11:0] C_SKY_RGB  = 12'h4CE;

  // Shadow positions, frozen for the whole visible frame
  logic       r_vblank_d;
  logic [9:0] r_bx, r_by, r_px, r_gy;
  logic       w_vrise;

  assign w_vrise     = vblank & ~r_vblank_d;
  assign frame_start = w_vrise & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vblank_d <= 1'b1;
      r_bx       <= '0;
      r_by       <= '0;
      r_px       <= '0;
      r_gy       <= '0;
    end else begin
      r_vblank_d <= vblank;
      if (w_vrise) begin
        r_bx <= bird_x;
        r_by <= bird_y;
        r_px <= pipe_x;
        r_gy <= gap_y;
      end
    end
  end

  // S0: region tests; edge sums are 11 bits wide so nothing wraps
  logic [10:0]            w_bx_end, w_by_end, w_px_end, w_gap_end;
  logic                   w_bird_hit, w_pipe_hit, w_gnd;
  logic [COL_W-1:0]       w_col;
  logic [ROW_W-1:0]       w_row;
  logic [ROW_W+COL_W-1:0] w_addr;

  assign w_bx_end   = {1'b0, r_bx} + C_SPR_W;
  assign w_by_end   = {1'b0, r_by} + C_SPR_H;
  assign w_px_end   = {1'b0, r_px} + C_PIPE_W;
  assign w_gap_end  = {1'b0, r_gy} + C_GAP_H;

  assign w_bird_hit = (CounterX >= {6'b0, r_bx}) && (CounterX < {5'b0, w_bx_end}) &&
                      (CounterY >= {6'b0, r_by}) && (CounterY < {5'b0, w_by_end});
  assign w_pipe_hit = (CounterX >= {6'b0, r_px}) && (CounterX < {5'b0, w_px_end}) &&
                      ((CounterY < {6'b0, r_gy}) || (CounterY >= {5'b0, w_gap_end}));
  assign w_gnd      = CounterY >= C_GROUND_Y;

  // Low bits of the offset only depend on low bits of the operands
  assign w_col  = CounterX[COL_W-1:0] - r_bx[COL_W-1:0];
  assign w_row  = CounterY[ROW_W-1:0] - r_by[ROW_W-1:0];
  assign w_addr = {w_row, w_col};

  logic r_bird0, r_pipe0, r_gnd0;
  logic r_bird1, r_pipe1, r_gnd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      spr_addr <= '0;
      r_bird0  <= 1'b0;
      r_pipe0  <= 1'b0;
      r_gnd0   <= 1'b0;
      r_bird1  <= 1'b0;
      r_pipe1  <= 1'b0;
      r_gnd1   <= 1'b0;
    end else begin
      spr_addr <= 8'(w_addr);
      r_bird0  <= w_bird_hit;
      r_pipe0  <= w_pipe_hit;
      r_gnd0   <= w_gnd;
      r_bird1  <= r_bird0;
      r_pipe1  <= r_pipe0;
      r_gnd1   <= r_gnd0;
    end
  end

  // S2: priority mux; blank/sync arrive here already two cycles late
  logic        w_blank, w_bird_op, w_coll_set;
  logic [11:0] w_rgb;

  assign w_blank    = hblank | vblank;
  assign w_bird_op  = r_bird1 & spr_data[12];
  assign w_coll_set = w_bird_op & (r_pipe1 | r_gnd1) & ~w_blank;

  always_comb begin
    w_rgb = C_SKY_RGB;
    if (w_blank)        w_rgb = 12'h000;
    else if (w_bird_op) w_rgb = spr_data[11:0];
    else if (r_pipe1)   w_rgb = C_PIPE_RGB;
    else if (r_gnd1)    w_rgb = C_GND_RGB;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb       <= 12'h000;
      vga_hs    <= 1'b0;
      vga_vs    <= 1'b0;
      blank_out <= 1'b1;
      collision <= 1'b0;
    end else begin
      rgb       <= w_rgb;
      vga_hs    <= h_sync_in;
      vga_vs    <= v_sync_in;
      blank_out <= w_blank;
      collision <= w_coll_set | (collision & ~collision_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_compositor.sv
`default_nettype none
// Testbench for frame_pixel_compositor: table vectors, corner sequences and
// randomized pixels checked against a per-pixel reference model.
module tb_frame_pixel_compositor;

  localparam int MAXC = 4096;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] CounterX, CounterY;
  logic        hblank, vblank, h_sync_in, v_sync_in;
  logic [9:0]  bird_x, bird_y, pipe_x, gap_y;
  logic [7:0]  spr_addr;
  logic [12:0] spr_data;
  logic        collision_clr;
  logic [11:0] rgb;
  logic        vga_hs, vga_vs, blank_out, frame_start, collision;

  always #5 Clk = ~Clk;

  frame_pixel_compositor dut (
    .Clk(Clk), .Reset(Reset), .CounterX(CounterX), .CounterY(CounterY),
    .hblank(hblank), .vblank(vblank), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .spr_addr(spr_addr), .spr_data(spr_data), .collision_clr(collision_clr),
    .rgb(rgb), .vga_hs(vga_hs), .vga_vs(vga_vs), .blank_out(blank_out),
    .frame_start(frame_start), .collision(collision)
  );

  logic [12:0] rom [256];
  always @(posedge Clk) spr_data <= rom[spr_addr];

  // Per-cycle history
  logic        s_hb [MAXC], s_vb [MAXC], s_hs [MAXC], s_vs [MAXC];
  logic        bl_h [MAXC], hs_h [MAXC], vs_h [MAXC], rst_h [MAXC], clr_h [MAXC];
  logic [11:0] e_rgb [MAXC], t_exp [MAXC];
  logic        e_set [MAXC], t_on [MAXC];

  int   n, tests, fails, fs_cnt;
  int   m_bx, m_by, m_px, m_gy;
  logic m_coll, m_vprev;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Reference pixel: colour (ignoring blank) and whether it is a collision pixel
  function automatic void model_pix(input int x, input int y, output logic [11:0] c, output logic hit);
    logic bird, op, pipe, gnd;
    logic [12:0] d;
    bird = (x >= m_bx) && (x < m_bx + 16) && (y >= m_by) && (y < m_by + 16);
    d    = bird ? rom[(y - m_by) * 16 + (x - m_bx)] : 13'h0;
    op   = bird && d[12];
    pipe = (x >= m_px) && (x < m_px + 52) && ((y < m_gy) || (y >= m_gy + 100));
    gnd  = (y >= 440);
    c    = op ? d[11:0] : pipe ? 12'h2A2 : gnd ? 12'hC95 : 12'h4CE;
    hit  = op && (pipe || gnd);
  endfunction

  task automatic check_outputs();
    logic vld, set;
    if (rst_h[n-1]) begin
      m_coll = 1'b0;
      chk("rst_rgb",   32'(rgb), 32'h0);
      chk("rst_blank", 32'(blank_out), 32'h1);
      chk("rst_sync",  32'({vga_hs, vga_vs}), 32'h0);
      chk("rst_coll",  32'(collision), 32'h0);
    end else begin
      vld    = (n >= 3) && !rst_h[n-3] && !rst_h[n-2];
      set    = vld && e_set[n-3];
      m_coll = set | (m_coll & ~clr_h[n-1]);
      chk("blank_out", 32'(blank_out), 32'(bl_h[n-1]));
      chk("vga_hs",    32'(vga_hs), 32'(hs_h[n-1]));
      chk("vga_vs",    32'(vga_vs), 32'(vs_h[n-1]));
      chk("collision", 32'(collision), 32'(m_coll));
      if (vld) chk("rgb_model", 32'(rgb), 32'(e_rgb[n-3]));
      if (vld && t_on[n-3]) chk("rgb_table", 32'(rgb), 32'(t_exp[n-3]));
    end
  endtask

  // One pixel-clock cycle: drive a counter sample, blank/sync lagging 2 cycles
  task automatic cycle(input int x, input int y, input logic rst, input logic clr,
                       input logic tc, input logic [11:0] te);
    logic [11:0] c;
    logic        hit, bl, fs_exp;
    Reset = rst; collision_clr = clr;
    CounterX = 16'(x); CounterY = 16'(y);
    s_hb[n] = (x >= 640); s_vb[n] = (y >= 480);
    s_hs[n] = (x >= 656) && (x < 752); s_vs[n] = (y == 490) || (y == 491);
    if (n >= 2) begin
      hblank = s_hb[n-2]; vblank = s_vb[n-2]; h_sync_in = s_hs[n-2]; v_sync_in = s_vs[n-2];
    end else begin
      hblank = 1'b1; vblank = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
    end
    bl_h[n] = hblank | vblank; hs_h[n] = h_sync_in; vs_h[n] = v_sync_in;
    rst_h[n] = rst; clr_h[n] = clr;
    model_pix(x, y, c, hit);
    bl = s_hb[n] | s_vb[n];
    e_rgb[n] = bl ? 12'h000 : c;
    e_set[n] = hit & ~bl;
    t_on[n] = tc; t_exp[n] = te;
    fs_exp = vblank & ~m_vprev & ~rst;
    #1;
    chk("frame_start", 32'(frame_start), 32'(fs_exp));
    if (frame_start === 1'b1) fs_cnt++;
    if (rst) begin
      m_bx = 0; m_by = 0; m_px = 0; m_gy = 0;
    end else if (fs_exp) begin
      m_bx = int'(bird_x); m_by = int'(bird_y); m_px = int'(pipe_x); m_gy = int'(gap_y);
    end
    m_vprev = rst ? 1'b1 : vblank;
    @(posedge Clk); #1;
    n++;
    check_outputs();
  endtask

  task automatic pix(input int x, input int y);
    cycle(x, y, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic tpix(input int x, input int y, input logic [11:0] e);
    cycle(x, y, 1'b0, 1'b0, 1'b1, e);
  endtask

  task automatic drain();
    repeat (3) pix(700, 0);
  endtask

  task automatic set_positions(input int bx, input int by, input int px, input int gy);
    bird_x = 10'(bx); bird_y = 10'(by); pipe_x = 10'(px); gap_y = 10'(gy);
    repeat (2) pix(0, 479);
    repeat (4) pix(0, 480);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  initial begin
    n = 0; tests = 0; fails = 0; fs_cnt = 0;
    m_bx = 0; m_by = 0; m_px = 0; m_gy = 0; m_coll = 1'b0; m_vprev = 1'b1;
    Reset = 1'b1; collision_clr = 1'b0; CounterX = '0; CounterY = '0;
    hblank = 1'b1; vblank = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
    bird_x = '0; bird_y = '0; pipe_x = '0; gap_y = '0;
    for (int i = 0; i < 256; i++) rom[i] = 13'h0000;

    tbl[0]  = '{0, 0, 12'h4CE};     tbl[1]  = '{100, 200, 12'hF00};
    tbl[2]  = '{115, 215, 12'hF00}; tbl[3]  = '{116, 200, 12'h4CE};
    tbl[4]  = '{99, 215, 12'h4CE};  tbl[5]  = '{100, 216, 12'h4CE};
    tbl[6]  = '{300, 149, 12'h2A2}; tbl[7]  = '{351, 0, 12'h2A2};
    tbl[8]  = '{352, 0, 12'h4CE};   tbl[9]  = '{299, 100, 12'h4CE};
    tbl[10] = '{300, 150, 12'h4CE}; tbl[11] = '{351, 249, 12'h4CE};
    tbl[12] = '{300, 250, 12'h2A2}; tbl[13] = '{0, 440, 12'hC95};
    tbl[14] = '{0, 439, 12'h4CE};   tbl[15] = '{320, 470, 12'h2A2};

    // Reset, blanked idle, then first active pixel is sky
    repeat (5) cycle(0, 0, 1'b1, 1'b0, 1'b0, 12'h000);
    repeat (3) pix(700, 500);
    tpix(0, 0, 12'h4CE);
    tpix(639, 0, 12'h4CE);
    drain();

    // Opaque red bird at (100,200), pipe at 300 with gap at 150
    for (int i = 0; i < 256; i++) rom[i] = 13'h1F00;
    set_positions(100, 200, 300, 150);
    for (int i = 0; i < 16; i++) tpix(tbl[i].x, tbl[i].y, tbl[i].exp);
    drain();

    // Mid-frame position change is ignored until the next vblank rise
    bird_x = 10'd400;
    tpix(100, 200, 12'hF00);
    tpix(400, 200, 12'h4CE);
    drain();
    fs_cnt = 0;
    set_positions(400, 200, 300, 150);
    chk("frame_start_once", 32'(fs_cnt), 32'd1);
    tpix(400, 200, 12'hF00);
    tpix(100, 200, 12'h4CE);
    drain();

    // Collision: set, sticky, set beats clear, clear alone
    set_positions(310, 130, 300, 150);
    chk("coll_idle", 32'(collision), 32'h0);
    pix(315, 135); pix(700, 0); pix(700, 0);
    chk("coll_set", 32'(collision), 32'h1);
    repeat (3) pix(700, 0);
    chk("coll_sticky", 32'(collision), 32'h1);
    pix(315, 135); pix(700, 0);
    cycle(700, 0, 1'b0, 1'b1, 1'b0, 12'h000);
    chk("coll_set_wins", 32'(collision), 32'h1);
    cycle(700, 0, 1'b0, 1'b1, 1'b0, 12'h000);
    chk("coll_clr", 32'(collision), 32'h0);
    drain();

    // Bird in the gap with transparent border rows/cols: no collision
    for (int i = 0; i < 256; i++)
      rom[i] = ((i / 16) >= 4 && (i / 16) <= 11 && (i % 16) >= 4 && (i % 16) <= 11) ? 13'h10F0 : 13'h0123;
    set_positions(292, 146, 300, 150);
    tpix(300, 146, 12'h2A2);
    tpix(300, 150, 12'h0F0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) pix(292 + c, 146 + r);
    drain();
    chk("coll_gap", 32'(collision), 32'h0);

    // Randomized frames against the model; round 0 sits at the 11-bit edge
    for (int r = 0; r < 4; r++) begin
      int bx, by, px, gy, x, y;
      drain();
      for (int i = 0; i < 256; i++) rom[i] = 13'($urandom);
      if (r == 0) begin
        bx = 1020; by = 1020; px = 1020; gy = int'($urandom_range(0, 1023));
      end else begin
        bx = int'($urandom_range(0, 700)); by = int'($urandom_range(0, 500));
        px = int'($urandom_range(0, 760)); gy = int'($urandom_range(0, 430));
      end
      set_positions(bx, by, px, gy);
      for (int i = 0; i < 300; i++) begin
        case ($urandom_range(0, 2))
          0:       x = clampi(bx - 8 + int'($urandom_range(0, 31)), 799);
          1:       x = clampi(px - 4 + int'($urandom_range(0, 59)), 799);
          default: x = int'($urandom_range(0, 799));
        endcase
        case ($urandom_range(0, 2))
          0:       y = clampi(by - 4 + int'($urandom_range(0, 23)), 524);
          1:       y = clampi(gy - 4 + int'($urandom_range(0, 8)) + (($urandom_range(0, 1) == 1) ? 100 : 0), 524);
          default: y = int'($urandom_range(0, 524));
        endcase
        cycle(x, y, 1'b0, ($urandom_range(0, 19) == 0), 1'b0, 12'h000);
      end
    end
    drain();

    // Reset mid-frame at (320,240)
    pix(318, 240); pix(319, 240);
    cycle(320, 240, 1'b1, 1'b0, 1'b0, 12'h000);
    chk("midrst_rgb", 32'(rgb), 32'h0);
    chk("midrst_blank", 32'(blank_out), 32'h1);
    tpix(321, 240, 12'h4CE);
    for (int i = 322; i < 332; i++) pix(i, 240);
    pix(700, 490); pix(700, 490); pix(700, 490);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
